// File: rtl/riscv_lsu_pkg.sv
// Shared encodings and lane helpers for the RV32I load/store unit.
// Covers funct3 codes, memory access sizes, FSM states and byte-lane placement/extension.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] BY_BYTE = 2'b00;
    localparam logic [1:0] BY_HALF = 2'b01;
    localparam logic [1:0] BY_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SPLIT  = 2'b10,
        RESP   = 2'b11
    } state_t;

    function automatic logic [1:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = BY_BYTE;
            2'b01:   size_of = BY_HALF;
            default: size_of = BY_WORD;
        endcase
    endfunction

    // Right-justified store data moved onto the lane(s) selected by the address offset.
    function automatic logic [31:0] place(input logic [31:0] data, input logic [1:0] offset,
                                          input logic [1:0] size);
        case (size)
            BY_BYTE: place = {24'd0, data[7:0]} << {offset, 3'b000};
            BY_HALF: place = {16'd0, data[15:0]} << {offset[1], 4'b0000};
            default: place = data;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] funct3);
        case (funct3)
            F3_B:    extend = {{24{data[7]}}, data[7:0]};
            F3_BU:   extend = {24'd0, data[7:0]};
            F3_H:    extend = {{16{data[15]}}, data[15:0]};
            F3_HU:   extend = {16'd0, data[15:0]};
            default: extend = data;
        endcase
    endfunction

endpackage

// File: rtl/riscv_load_ext.sv
// Load data lane selection and sign/zero extension (combinational).
// lane_byte exposes the selected byte alone so the split path can accumulate byte by byte.
module riscv_load_ext
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [7:0]  lane_byte,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Aligned halves always have offset[0]=0, so one byte-granular shift serves every size.
    assign shifted   = rdata >> {offset, 3'b000};
    assign lane_byte = shifted[7:0];
    assign data      = extend(shifted, funct3);

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store initiator for a byte-lane, address-aligning data memory.
// Aligned accesses take one memory cycle; misaligned ones are split into byte accesses.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_by,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_re,
    output logic        mem_we
);

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] acc;
    logic [1:0]  cnt;
    logic        split_q;
    logic        err_q;

    logic [1:0]  size_in, size_q;
    logic        illegal_in, misal_in, reject_in;
    logic [31:0] split_addr;
    logic [1:0]  ext_off;
    logic [7:0]  ext_byte;
    logic [31:0] ext_data;
    logic        last_cnt;

    assign size_in    = size_of(req_funct3);
    assign size_q     = size_of(f3_q);
    assign illegal_in = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    assign misal_in   = ((size_in == BY_HALF) && req_addr[0]) ||
                        ((size_in == BY_WORD) && (req_addr[1:0] != 2'b00));
    assign reject_in  = illegal_in || (misal_in && !ALLOW_MISALIGNED);

    // Wraps naturally past 0xFFFFFFFF.
    assign split_addr = addr_q + {30'd0, cnt};
    assign last_cnt   = (cnt == ((size_q == BY_HALF) ? 2'd1 : 2'd3));
    assign ext_off    = (state == SPLIT) ? split_addr[1:0] : addr_q[1:0];

    riscv_load_ext u_load_ext (
        .rdata     (mem_rdata),
        .offset    (ext_off),
        .funct3    (f3_q),
        .lane_byte (ext_byte),
        .data      (ext_data)
    );

    // Every output is forced to 0 while rst_n is low, not just after the reset edge.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        mem_addr  = 32'd0;
        mem_by    = BY_BYTE;
        mem_wdata = 32'd0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        if (reject_in)     state_nx = RESP;
                        else if (misal_in) state_nx = SPLIT;
                        else               state_nx = ACCESS;
                    end
                end
                ACCESS: begin
                    mem_addr = addr_q;
                    mem_by   = size_q;
                    mem_we   = we_q;
                    mem_re   = !we_q;
                    if (we_q) mem_wdata = place(wdata_q, addr_q[1:0], size_q);
                    state_nx = RESP;
                end
                SPLIT: begin
                    mem_addr = split_addr;
                    mem_by   = BY_BYTE;
                    mem_we   = we_q;
                    mem_re   = !we_q;
                    if (we_q)
                        mem_wdata = place({24'd0, wdata_q[{cnt, 3'b000} +: 8]},
                                          split_addr[1:0], BY_BYTE);
                    if (last_cnt) state_nx = RESP;
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_err   = err_q;
                    if (!err_q && !we_q) rsp_rdata = split_q ? extend(acc, f3_q) : acc;
                    state_nx  = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            acc     <= 32'd0;
            cnt     <= 2'd0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        acc     <= 32'd0;
                        cnt     <= 2'd0;
                        err_q   <= reject_in;
                        split_q <= misal_in && !reject_in;
                    end
                end
                ACCESS: begin
                    if (!we_q) acc <= ext_data;
                end
                SPLIT: begin
                    if (!we_q) acc[{cnt, 3'b000} +: 8] <= ext_byte;
                    cnt <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
